// File: rtl/ifetch_resp.sv
// Instruction fetch response path: one-cycle SRAM read slot feeding an
// in-order response buffer toward decode, with flush redirect and busy backpressure.
`timescale 1ns/1ps
module ifetch_resp #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_ce,
  input  logic [AW-1:0] req_pc,
  input  logic          flush,
  input  logic          stall,
  output logic          busy,
  output logic          mem_en,
  output logic [AW-3:0] mem_addr,
  input  logic [IW-1:0] mem_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [IW-1:0] if_inst,
  output logic          if_misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] r_buf_pc   [DEPTH];
  logic [IW-1:0] r_buf_inst [DEPTH];
  logic          r_buf_mis  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          r_inf_valid;
  logic [AW-1:0] r_inf_pc;
  logic          r_inf_mis;

  logic          w_accept;
  logic          w_aligned;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_occ;

  // Occupancy counts the in-flight slot so a buffer slot is always free for it.
  assign w_occ     = r_count + CW'(r_inf_valid);
  assign busy      = !rst && (w_occ >= FULL);
  assign w_accept  = !rst && req_ce && (!busy || flush);
  assign w_aligned = (req_pc[1:0] == 2'b00);
  assign mem_en    = w_accept && w_aligned;
  assign mem_addr  = req_pc[AW-1:2];

  assign if_valid    = (r_count != '0);
  assign w_pop       = if_valid && !stall;
  assign w_push      = r_inf_valid;
  assign if_pc       = if_valid ? r_buf_pc[r_head]   : '0;
  assign if_inst     = if_valid ? r_buf_inst[r_head] : '0;
  assign if_misalign = if_valid ? r_buf_mis[r_head]  : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_inf_valid <= 1'b0;
    end else if (flush) begin
      // The request accepted alongside the flush is the redirect target and survives.
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_inf_valid <= w_accept;
    end else begin
      r_inf_valid <= w_accept;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_inf_pc  <= req_pc;
      r_inf_mis <= !w_aligned;
    end
    if (!rst && !flush && w_push) begin
      r_buf_pc[r_tail]   <= r_inf_pc;
      r_buf_inst[r_tail] <= r_inf_mis ? '0 : mem_rdata;
      r_buf_mis[r_tail]  <= r_inf_mis;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !flush && (r_count == FULL) && !w_pop));

endmodule

// File: tb/tb_ifetch_resp.sv
// Scoreboard bench for ifetch_resp: the driver queues expected responses on
// acceptance, an independent monitor compares whatever decode is presented.
`timescale 1ns/1ps
module tb_ifetch_resp;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ce = 1'b0;
  logic [31:0] req_pc = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        busy;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  logic        o_busy, o_ifv, o_mis, last_acc;
  logic [31:0] o_pc, o_inst;

  ifetch_resp dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_pc(req_pc), .flush(flush),
    .stall(stall), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // SRAM model: data only valid the cycle after a read, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? inst_of(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic r, input logic ce, input logic [31:0] pc,
                     input logic st, input logic fl);
    logic acc;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req_ce = ce; req_pc = pc; stall = st; flush = fl;
    @(negedge clk);
    o_busy = busy; o_ifv = if_valid; o_pc = if_pc; o_inst = if_inst; o_mis = if_misalign;
    acc = !r && ce && (!busy || fl);
    chk("mem_en", 64'(mem_en), 64'(acc && (pc[1:0] == 2'b00)));
    if (mem_en) chk("mem_addr", 64'(mem_addr), 64'(pc[31:2]));
    if (r || fl) q.delete();
    if (acc) begin
      e.pc   = pc;
      e.mis  = (pc[1:0] != 2'b00);
      e.inst = e.mis ? 32'h0 : inst_of(pc[31:2]);
      q.push_back(e);
    end
    last_acc = acc;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares presented head against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && if_valid) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: if_pc %0h presented with nothing expected", if_pc);
      end else begin
        chk("resp_pc", 64'(if_pc), 64'(q[0].pc));
        chk("resp_inst", 64'(if_inst), 64'(q[0].inst));
        chk("resp_mis", 64'(if_misalign), 64'(q[0].mis));
        if (!stall) void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] rpc;
    logic        ce, st, fl;

    // Reset: request during reset must not reach memory
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_ifv", 64'(o_ifv), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    chk("rst_mis", 64'(o_mis), 64'd0);
    chk("rst_busy2", 64'(o_busy), 64'd0);

    // Back-to-back fetch of 0,4,8: first response two cycles after accept
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("lat_c0", 64'(o_ifv), 64'd0);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0);
    chk("lat_c1", 64'(o_ifv), 64'd0);
    cyc(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    chk("lat_c2_v", 64'(o_ifv), 64'd1);
    chk("lat_c2_pc", 64'(o_pc), 64'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_c3_pc", 64'(o_pc), 64'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_c4_pc", 64'(o_pc), 64'h8);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_c5_v", 64'(o_ifv), 64'd0);
    drain(2);

    // Stalled decode: fills to 3 buffered + 1 in flight, then drains in order
    pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, pc, (k < 6), 1'b0);
      if (k == 3) chk("stall_busy_k3", 64'(o_busy), 64'd0);
      if (k == 4) chk("stall_busy_k4", 64'(o_busy), 64'd1);
      if (k >= 2 && k < 6) chk("stall_frozen_pc", 64'(o_pc), 64'h0);
      if (last_acc) pc = pc + 32'h4;
    end
    drain(10);

    // Flush with 2 buffered + 1 in flight: only the redirect target survives
    cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h204, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h208, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_next_ifv", 64'(o_ifv), 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_tgt_v", 64'(o_ifv), 64'd1);
    chk("flush_tgt_pc", 64'(o_pc), 64'h100);
    drain(4);

    // Misaligned request between aligned neighbours
    cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h6, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h14, 1'b0, 1'b0);
    chk("mis_prev_pc", 64'(o_pc), 64'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_pc", 64'(o_pc), 64'h6);
    chk("mis_flag", 64'(o_mis), 64'd1);
    chk("mis_inst", 64'(o_inst), 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_next_pc", 64'(o_pc), 64'h14);
    drain(3);

    // Reset mid-operation with a full pipeline
    cyc(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h304, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h308, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h30C, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h310, 1'b1, 1'b0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("midrst_ifv", 64'(o_ifv), 64'd0);
    chk("midrst_pc", 64'(o_pc), 64'd0);
    chk("midrst_inst", 64'(o_inst), 64'd0);
    chk("midrst_mis", 64'(o_mis), 64'd0);
    chk("midrst_busy2", 64'(o_busy), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("midrst_no_stale", 64'(o_ifv), 64'd0);
    end

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      ce  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      cyc(1'b0, ce, rpc, st, fl);
    end
    drain(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
